// File: rtl/miner_core_compress_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : miner_core_pkg
// Brief   : Shared SHA-256 types, round constants, IV and helpers.
// Revision: 1.0 - initial release
// ============================================================================
package miner_core_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [0:7]  hash_t;
    typedef word_t [0:63] sched_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } state_t;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam hash_t H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Callers pass constant amounts in 1..31.
    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/miner_core_compress_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : miner_core_compress_if
// Brief   : Request/result bundle between the scheduler side and compressor.
// Revision: 1.0 - initial release
// ============================================================================
interface miner_core_compress_if;
    import miner_core_pkg::*;

    logic   start;
    logic   abort;
    sched_t w;
    hash_t  h_in;
    logic   busy;
    logic   done;
    hash_t  digest;

    modport master (output start, abort, w, h_in, input busy, done, digest);
    modport slave  (input start, abort, w, h_in, output busy, done, digest);
endinterface
`default_nettype wire

// File: rtl/miner_core_compress_round.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : miner_core_round
// Brief   : One combinational SHA-256 round: a..h, W[t], K[t] -> next a..h.
// Revision: 1.0 - initial release
// ============================================================================
module miner_core_round
    import miner_core_pkg::*;
(
    input  hash_t i_var,
    input  word_t i_w,
    input  word_t i_k,
    output hash_t o_var
);

    word_t w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    word_t w_s1, w_ch, w_t1, w_s0, w_maj, w_t2;

    always_comb begin
        {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_var;
        w_s1  = rotr(w_e, 6) ^ rotr(w_e, 11) ^ rotr(w_e, 25);
        w_ch  = (w_e & w_f) ^ (~w_e & w_g);
        w_t1  = w_h + w_s1 + w_ch + i_k + i_w;
        w_s0  = rotr(w_a, 2) ^ rotr(w_a, 13) ^ rotr(w_a, 22);
        w_maj = (w_a & w_b) ^ (w_a & w_c) ^ (w_b & w_c);
        w_t2  = w_s0 + w_maj;
        o_var = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};
    end

endmodule
`default_nettype wire

// File: rtl/miner_core_compress.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : miner_core_compress
// Brief   : SHA-256 compression engine, one round per clock plus final add.
// Revision: 1.0 - initial release
// ============================================================================
module miner_core_compress #(
    parameter int ROUNDS = 64
) (
    input  wire logic            clk,
    input  wire logic            n_rst,
    miner_core_compress_if.slave bus
);
    import miner_core_pkg::*;

    state_t     r_state;
    state_t     w_next_state;
    logic [5:0] r_cnt;
    hash_t      r_var;
    hash_t      r_saved;
    hash_t      r_digest;
    logic       r_done;

    hash_t      w_round_out;
    hash_t      w_sum;
    logic       w_last;
    logic       w_busy;
    logic       w_load;
    logic       w_step;
    logic       w_finish;

    assign w_last = (r_cnt == 6'(ROUNDS - 1));

    miner_core_round u_round (
        .i_var (r_var),
        .i_w   (bus.w[r_cnt]),
        .i_k   (K[r_cnt]),
        .o_var (w_round_out)
    );

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_sum
            assign w_sum[gi] = r_saved[gi] + r_var[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Abort overrides every transition, including start in IDLE.
    always_comb begin
        w_next_state = r_state;
        if (bus.abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (bus.start) w_next_state = ST_ROUND;
                ST_ROUND: if (w_last)    w_next_state = ST_FINAL;
                ST_FINAL: w_next_state = ST_IDLE;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy   = (r_state == ST_ROUND) || (r_state == ST_FINAL);
        w_load   = (r_state == ST_IDLE)  && bus.start && !bus.abort;
        w_step   = (r_state == ST_ROUND) && !bus.abort;
        w_finish = (r_state == ST_FINAL) && !bus.abort;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt    <= '0;
            r_var    <= '0;
            r_saved  <= '0;
            r_digest <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_var   <= bus.h_in;
                r_saved <= bus.h_in;
                r_cnt   <= '0;
            end else if (w_step) begin
                r_var <= w_round_out;
                r_cnt <= w_last ? 6'd0 : r_cnt + 6'd1;
            end else if (bus.abort) begin
                r_cnt <= '0;
            end
            if (w_finish) r_digest <= w_sum;
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = r_done;
    assign bus.digest = r_digest;

endmodule
`default_nettype wire

// File: tb/tb_miner_core_compress.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_miner_core_compress
// Brief   : Directed self-checking bench with digest scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_miner_core_compress;
    import miner_core_pkg::*;

    localparam logic [255:0] ABC_D   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_D = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] TWO_D   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    miner_core_compress_if bus ();

    miner_core_compress #(.ROUNDS(64)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    logic [255:0] sb_q [$];

    function automatic word_t sig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic sched_t expand(input sched_t s);
        sched_t r;
        r = s;
        for (int t = 16; t < 64; t++)
            r[t] = sig1(r[t-2]) + r[t-7] + sig0(r[t-15]) + r[t-16];
        return r;
    endfunction

    function automatic hash_t ref_compress(input hash_t hin, input sched_t ws);
        word_t a, b, c, d, e, f, g, h, t1, t2;
        hash_t r;
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + ws[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        r = {a, b, c, d, e, f, g, h};
        for (int i = 0; i < 8; i++) r[i] = r[i] + hin[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.done === 1'b1) begin
            n_done++;
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_done observed=done_pulse expected=no_pending_result");
            end
            if (sb_q.size() != 0) check("digest", bus.digest, sb_q.pop_front());
        end
    endtask

    task automatic start_block(input sched_t ws, input hash_t hs, input logic [255:0] exp, input bit push);
        bus.w     = ws;
        bus.h_in  = hs;
        bus.start = 1'b1;
        if (push) sb_q.push_back(exp);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int lat;
        int seen;
        lat  = 0;
        seen = n_done;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (n_done != seen) begin
                lat = i;
                break;
            end
        end
        check(tag, 256'(lat), 256'd65);
    endtask

    sched_t s_abc, s_empty, s_b1, s_b2;
    hash_t  mid;
    int     seen, lat;

    initial begin
        s_abc = '0;   s_abc[0] = 32'h61626380; s_abc[15] = 32'h00000018;
        s_abc = expand(s_abc);
        s_empty = '0; s_empty[0] = 32'h80000000;
        s_empty = expand(s_empty);
        s_b1 = '0;
        s_b1[0]  = 32'h61626364; s_b1[1]  = 32'h62636465; s_b1[2]  = 32'h63646566;
        s_b1[3]  = 32'h64656667; s_b1[4]  = 32'h65666768; s_b1[5]  = 32'h66676869;
        s_b1[6]  = 32'h6768696a; s_b1[7]  = 32'h68696a6b; s_b1[8]  = 32'h696a6b6c;
        s_b1[9]  = 32'h6a6b6c6d; s_b1[10] = 32'h6b6c6d6e; s_b1[11] = 32'h6c6d6e6f;
        s_b1[12] = 32'h6d6e6f70; s_b1[13] = 32'h6e6f7071; s_b1[14] = 32'h80000000;
        s_b1 = expand(s_b1);
        s_b2 = '0; s_b2[15] = 32'h000001c0;
        s_b2 = expand(s_b2);

        n_rst = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.w = '0; bus.h_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   256'(bus.busy),   256'd0);
        check("reset_done",   256'(bus.done),   256'd0);
        check("reset_digest", bus.digest,       256'd0);
        n_rst = 1'b1;
        tick();

        // "abc" single block
        start_block(s_abc, H0, ABC_D, 1'b1);
        check("busy_after_start", 256'(bus.busy), 256'd1);
        wait_done("lat_abc");
        check("busy_in_done_cycle", 256'(bus.busy), 256'd0);
        tick();
        check("done_one_cycle", 256'(bus.done), 256'd0);
        check("digest_held", bus.digest, ABC_D);

        // Empty message
        start_block(s_empty, H0, EMPTY_D, 1'b1);
        wait_done("lat_empty");

        // Stray starts with corrupted h_in while busy must be ignored
        start_block(s_abc, H0, ABC_D, 1'b1);
        seen = n_done; lat = 0;
        for (int i = 1; i <= 100; i++) begin
            if (i == 10 || i == 40) begin
                bus.start = 1'b1;
                bus.h_in  = ~H0;
            end
            tick();
            bus.start = 1'b0;
            bus.h_in  = H0;
            if (n_done != seen && lat == 0) lat = i;
        end
        check("lat_stray_start", 256'(lat), 256'd65);
        check("done_count_stray", 256'(n_done - seen), 256'd1);

        // Abort at round 30
        start_block(s_abc, H0, '0, 1'b0);
        repeat (30) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy_drop", 256'(bus.busy), 256'd0);
        seen = n_done;
        repeat (80) tick();
        check("abort_no_done", 256'(n_done - seen), 256'd0);
        check("abort_digest_kept", bus.digest, ABC_D);

        // Abort and start together in IDLE: abort wins
        bus.w = s_empty; bus.h_in = H0; bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        check("abort_start_idle", 256'(bus.busy), 256'd0);
        seen = n_done;
        repeat (70) tick();
        check("abort_start_no_done", 256'(n_done - seen), 256'd0);

        start_block(s_abc, H0, ABC_D, 1'b1);
        wait_done("lat_after_abort");

        // Two-block message, second start issued in the done cycle
        mid = ref_compress(H0, s_b1);
        start_block(s_b1, H0, mid, 1'b1);
        wait_done("lat_b2b_first");
        start_block(s_b2, mid, TWO_D, 1'b1);
        check("b2b_busy", 256'(bus.busy), 256'd1);
        wait_done("lat_b2b_second");

        // Asynchronous reset mid-run
        start_block(s_abc, H0, '0, 1'b0);
        repeat (20) tick();
        n_rst = 1'b0;
        #1;
        check("rst_mid_busy",   256'(bus.busy), 256'd0);
        check("rst_mid_done",   256'(bus.done), 256'd0);
        check("rst_mid_digest", bus.digest,     256'd0);
        tick();
        n_rst = 1'b1;
        seen = n_done;
        repeat (70) tick();
        check("rst_mid_no_done", 256'(n_done - seen), 256'd0);
        start_block(s_abc, H0, ABC_D, 1'b1);
        wait_done("lat_after_reset");
        tick();

        check("scoreboard_drained", 256'(sb_q.size()), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
